// File: rtl/cmd_loader_if.sv
// Byte-stream input and program-memory write port of the cmd loader.
// master = host / memory side, slave = loader side.
interface cmd_loader_if #(
  parameter int unsigned CMD_WIDTH      = 39,
  parameter int unsigned CMD_ADDR_WIDTH = 6
);
  logic                      in_valid;
  logic [7:0]                in_data;
  logic                      in_ready;
  logic                      wr_en;
  logic [CMD_ADDR_WIDTH-1:0] wr_addr;
  logic [CMD_WIDTH-1:0]      wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/cmd_loader.sv
// Program loader: assembles big-endian instruction words from a byte stream,
// writes them to cmd memory and releases cpu reset once the XOR checksum matches.
module cmd_loader #(
  parameter int unsigned CMD_WIDTH      = 39,
  parameter int unsigned CMD_ADDR_WIDTH = 6,
  parameter int unsigned BYTES_PER_CMD  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  cmd_loader_if.slave             bus,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [CMD_ADDR_WIDTH:0] count
);

  localparam int unsigned CNT_W = CMD_ADDR_WIDTH + 1;
  localparam int unsigned IDX_W = (BYTES_PER_CMD > 1) ? $clog2(BYTES_PER_CMD) : 1;
  localparam int unsigned DEPTH = 2 ** CMD_ADDR_WIDTH;
  localparam int unsigned ASM_W = CMD_WIDTH - 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          n_q;
  logic [CNT_W-1:0]          cmd_idx_q;
  logic [CNT_W-1:0]          count_q;
  logic [IDX_W-1:0]          byte_idx_q;
  logic [ASM_W-1:0]          asm_q;
  logic [7:0]                xor_q;
  logic                      wr_en_q;
  logic [CMD_ADDR_WIDTH-1:0] wr_addr_q;
  logic [CMD_WIDTH-1:0]      wr_data_q;

  logic session;
  logic accept;
  logic last_byte;
  logic last_cmd;
  logic hdr_bad;

  assign session   = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign accept    = bus.in_valid && session;
  assign last_byte = (byte_idx_q == IDX_W'(BYTES_PER_CMD - 1));
  // cmd_idx counts assembled words, so the final byte is recognised before its write lands
  assign last_cmd  = ((cmd_idx_q + 1'b1) == n_q);
  assign hdr_bad   = (bus.in_data == '0) || (32'(bus.in_data) > DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (accept) state_d = hdr_bad ? ERR : DATA;
      end
      DATA: begin
        if (accept && last_byte && last_cmd) state_d = CSUM;
      end
      CSUM: begin
        if (accept) state_d = (bus.in_data == xor_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q        <= '0;
      cmd_idx_q  <= '0;
      count_q    <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      xor_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (wr_en_q) begin
        wr_addr_q <= wr_addr_q + 1'b1;
        count_q   <= count_q + 1'b1;
      end

      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            cmd_idx_q  <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            xor_q      <= '0;
            wr_addr_q  <= '0;
          end
        end
        HDR: begin
          if (accept) n_q <= CNT_W'(bus.in_data);
        end
        DATA: begin
          if (accept) begin
            asm_q <= {asm_q[ASM_W-9:0], bus.in_data};
            xor_q <= xor_q ^ bus.in_data;
            if (last_byte) begin
              // word is captured separately so the next byte may shift in during the write
              byte_idx_q <= '0;
              cmd_idx_q  <= cmd_idx_q + 1'b1;
              wr_en_q    <= 1'b1;
              wr_data_q  <= {asm_q, bus.in_data};
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = session;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = session;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign cpu_reset    = (state_q != DONE);
  assign count        = count_q;

endmodule
